// File: rtl/sprite_pos_pkg.sv
// Shared types and defaults for the sprite position bank.
//   pos_state_t  : per-channel handshake state (idle / move in progress)
//   DEF_POS_W    : default packed board-position word width
//   DEF_INIT_POS : default position loaded on reset and on channel clear
package sprite_pos_pkg;

    typedef enum logic {
        PS_IDLE = 1'b0,
        PS_MOVE = 1'b1
    } pos_state_t;

    localparam int unsigned DEF_POS_W = 28;
    localparam logic [DEF_POS_W-1:0] DEF_INIT_POS = 28'd0;

endpackage

// File: rtl/pos_channel.sv
// One sprite channel: IDLE/MOVE handshake against the mover's done flag,
// committed position register, move timeout and committed-move counter.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   done_move         : mover done flag (low while the sprite is moving)
//   position_in       : live position from the mover
//   clear             : synchronous channel clear (beats done_move and freeze)
//   freeze            : global hold; commit forced low
//   position          : committed position
//   moving            : channel is in PS_MOVE
//   commit            : one-cycle pulse when position is latched
//   timeout           : sticky move-timeout flag
//   move_count        : wrapping count of committed moves
module pos_channel
    import sprite_pos_pkg::*;
#(
    parameter int unsigned      POS_W     = DEF_POS_W,
    parameter logic [POS_W-1:0] INIT_POS  = POS_W'(DEF_INIT_POS),
    parameter int unsigned      TIMEOUT_W = 20,
    parameter int unsigned      CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             done_move,
    input  logic [POS_W-1:0] position_in,
    input  logic             clear,
    input  logic             freeze,
    output logic [POS_W-1:0] position,
    output logic             moving,
    output logic             commit,
    output logic             timeout,
    output logic [CNT_W-1:0] move_count
);

    // Counter value at which a stalled move is abandoned.
    localparam logic [TIMEOUT_W-1:0] TO_LAST = '1;

    pos_state_t             state_q;
    pos_state_t             state_d;
    logic [TIMEOUT_W-1:0]   tcnt_q;
    logic [TIMEOUT_W-1:0]   tcnt_d;
    logic [POS_W-1:0]       position_d;
    logic                   moving_d;
    logic                   commit_d;
    logic                   timeout_d;
    logic [CNT_W-1:0]       move_count_d;

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= PS_IDLE;
            tcnt_q     <= '0;
            position   <= INIT_POS;
            moving     <= 1'b0;
            commit     <= 1'b0;
            timeout    <= 1'b0;
            move_count <= '0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            position   <= position_d;
            moving     <= moving_d;
            commit     <= commit_d;
            timeout    <= timeout_d;
            move_count <= move_count_d;
        end
    end

    // Next-state and output logic; everything holds unless a rule fires.
    always_comb begin
        state_d      = state_q;
        tcnt_d       = tcnt_q;
        position_d   = position;
        commit_d     = 1'b0;
        timeout_d    = timeout;
        move_count_d = move_count;

        if (clear) begin
            state_d      = PS_IDLE;
            tcnt_d       = '0;
            position_d   = INIT_POS;
            timeout_d    = 1'b0;
            move_count_d = '0;
        end else if (!freeze) begin
            case (state_q)
                PS_IDLE: begin
                    // A low done flag is needed to start; a held-high flag never retriggers.
                    if (!done_move) begin
                        state_d = PS_MOVE;
                        tcnt_d  = '0;
                    end
                end
                PS_MOVE: begin
                    if (done_move) begin
                        state_d      = PS_IDLE;
                        position_d   = position_in;
                        commit_d     = 1'b1;
                        move_count_d = move_count + CNT_W'(1);
                    end else begin
                        tcnt_d = tcnt_q + TIMEOUT_W'(1);
                        // Abandon the move without latching; the flag is sticky.
                        if (tcnt_d == TO_LAST) begin
                            state_d   = PS_IDLE;
                            timeout_d = 1'b1;
                        end
                    end
                end
                default: state_d = PS_IDLE;
            endcase
        end

        moving_d = (state_d == PS_MOVE);
    end

endmodule

// File: rtl/sprite_position_bank.sv
// Committed-position bank for N_CH sprites (channel 0 is Qbert).
// Each channel runs its own move handshake; this level flags Qbert-versus-enemy
// collisions one cycle after any channel commits.
// Ports:
//   clk, reset    : clock, asynchronous active-low reset
//   done_move     : per-channel mover done flags
//   position_in   : per-channel live positions, channel k at [k*POS_W +: POS_W]
//   clear_ch      : per-channel synchronous clear
//   freeze        : global hold (pause screen)
//   dff_position  : committed positions, same packing as position_in
//   moving        : per-channel move in progress
//   commit        : per-channel one-cycle latch pulse
//   timeout       : per-channel sticky move timeout
//   move_count    : per-channel committed-move counters, channel k at [k*CNT_W +: CNT_W]
//   collide       : one-cycle pulse, Qbert position equals some enemy position
//   collide_ch    : enemies matched on that pulse (bit 0 always 0)
module sprite_position_bank
    import sprite_pos_pkg::*;
#(
    parameter int unsigned      N_CH      = 4,
    parameter int unsigned      POS_W     = DEF_POS_W,
    parameter logic [POS_W-1:0] INIT_POS  = POS_W'(DEF_INIT_POS),
    parameter int unsigned      TIMEOUT_W = 20,
    parameter int unsigned      CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         done_move,
    input  logic [N_CH*POS_W-1:0]   position_in,
    input  logic [N_CH-1:0]         clear_ch,
    input  logic                    freeze,
    output logic [N_CH*POS_W-1:0]   dff_position,
    output logic [N_CH-1:0]         moving,
    output logic [N_CH-1:0]         commit,
    output logic [N_CH-1:0]         timeout,
    output logic [N_CH*CNT_W-1:0]   move_count,
    output logic                    collide,
    output logic [N_CH-1:0]         collide_ch
);

    logic [N_CH-1:0] match_c;

    // Per-sprite handshake channels.
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        pos_channel #(
            .POS_W     (POS_W),
            .INIT_POS  (INIT_POS),
            .TIMEOUT_W (TIMEOUT_W),
            .CNT_W     (CNT_W)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .done_move   (done_move[k]),
            .position_in (position_in[k*POS_W +: POS_W]),
            .clear       (clear_ch[k]),
            .freeze      (freeze),
            .position    (dff_position[k*POS_W +: POS_W]),
            .moving      (moving[k]),
            .commit      (commit[k]),
            .timeout     (timeout[k]),
            .move_count  (move_count[k*CNT_W +: CNT_W])
        );
    end

    // Full-word compare of each enemy against Qbert; Qbert never matches itself.
    assign match_c[0] = 1'b0;
    for (genvar k = 1; k < N_CH; k++) begin : g_match
        assign match_c[k] = (dff_position[0 +: POS_W] == dff_position[k*POS_W +: POS_W]);
    end

    // Evaluate once on the cycle after any commit, seeing the freshly latched positions.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            collide    <= 1'b0;
            collide_ch <= '0;
        end else if (freeze) begin
            collide    <= 1'b0;
            collide_ch <= '0;
        end else if (|commit) begin
            collide    <= |match_c;
            collide_ch <= match_c;
        end else begin
            collide    <= 1'b0;
            collide_ch <= '0;
        end
    end

endmodule

// File: doc/sprite_position_bank.md
# sprite_position_bank

Multi-channel successor to the single-sprite position latch: tracks the committed board position of up to N_CH sprites (Qbert plus enemies). Each channel runs its own IDLE/MOVE handshake against the mover's done flag and adds move timeout, per-channel clear, global freeze, move counting and Qbert-versus-enemy collision flagging. Sits between the per-sprite movement FSMs and the renderer/game-logic blocks that consume registered positions.

## Interface
- N_CH, 4: number of sprite channels; channel 0 is Qbert.
- POS_W, 28: packed position word width.
- INIT_POS, 28'd0: position loaded on reset and on clear.
- TIMEOUT_W, 20: move timeout counter width.
- CNT_W, 8: per-channel committed-move counter width.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- done_move  in  N_CH  per-channel mover done flag; low while moving.
- position_in  in  N_CH*POS_W  per-channel live position; channel k at [k*POS_W +: POS_W].
- clear_ch  in  N_CH  synchronous per-channel clear.
- freeze  in  1  global hold (pause screen).
- dff_position  out  N_CH*POS_W  committed positions.
- moving  out  N_CH  channel in MOVE.
- commit  out  N_CH  one-cycle pulse on latch.
- timeout  out  N_CH  sticky move-timeout flag.
- move_count  out  N_CH*CNT_W  committed moves, wrapping.
- collide  out  1  one-cycle pulse: Qbert shares a position with any enemy.
- collide_ch  out  N_CH  enemies matched on that pulse; bit 0 always 0.

## Operation
- Per-channel FSM, states PS_IDLE, PS_MOVE.
- PS_IDLE -> PS_MOVE when done_move[k]==0; timeout counter cleared on entry.
- PS_MOVE -> PS_IDLE when done_move[k]==1: dff_position[k] <= position_in[k], commit[k] pulses, move_count[k] increments (wraps 2^CNT_W-1 -> 0).
- In PS_MOVE the counter increments each cycle; on reaching 2^TIMEOUT_W-1 with done_move still 0: timeout[k] set, return to PS_IDLE, no latch, no commit, no count.
- timeout[k] stays set until clear_ch[k] or reset; does not block new moves.
- clear_ch[k]: state PS_IDLE, dff_position[k] <= INIT_POS, timeout, counter and move_count cleared; no commit. Priority over done_move and freeze.
- freeze: all FSMs, timeout counters and outputs hold; done_move ignored; commit and collide forced 0.
- Collision: evaluated the cycle after any commit bit was high, on full-word equality dff_position[0]==dff_position[k], k=1..N_CH-1; collide = OR of matches, collide_ch = match vector, both for one cycle.

## Timing
- Reset values: moving 0, commit 0, timeout 0, move_count 0, collide 0, collide_ch 0, dff_position INIT_POS every channel, all FSMs PS_IDLE.
- done_move low sampled at edge n -> moving high after n. done_move high sampled in PS_MOVE at edge m -> dff_position, commit, move_count updated after m; commit low after m+1.
- collide/collide_ch valid after m+1 (one cycle after commit).
- Simultaneous commits on several channels in one cycle: all latch; one collide evaluation.
- done_move already high on entry to PS_IDLE: no re-trigger; a low is required first.
- Reset mid-move: immediate return to reset values; no partial latch.
- Timeout fires exactly 2^TIMEOUT_W-1 cycles after PS_MOVE entry.

## Structure
- Package sprite_pos_pkg: pos_state_t enum (PS_IDLE, PS_MOVE), default POS_W and INIT_POS constants.
- Sub-module pos_channel: one FSM, timeout counter, position register, move counter; generate-instantiated N_CH times.
- Top level holds only the collision comparator and its output registers.

## Test plan
- Reset with reset=0 mid-stream -> all dff_position==0, moving/commit/timeout/move_count/collide==0.
- Ch1: done_move 1->0->1 with position_in=28'h0012345 -> moving for the low cycles, commit[1] one cycle, dff_position[1]==28'h0012345, move_count[1]==1.
- TIMEOUT_W=4, ch2 held low 20 cycles -> timeout[2] set at cycle 15, no commit, dff_position[2] unchanged; clear_ch[2] clears it.
- Ch0 and ch3 commit 28'h00A0B0C in the same cycle -> collide pulse next cycle, collide_ch==4'b1000.
- freeze high during ch1 move, done_move rises -> no latch; freeze released with done_move still high -> commit on next edge.
- 256 commits on ch1 with CNT_W=8 -> move_count[1] wraps to 0.
